// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline control types: flush codes, fetch/data handshake states and the
// per-stage stall vector used by the hazard sequencer.
package pipes;

    typedef enum logic {
        RESET_CONTINUE = 1'b0,
        RESET_RESET    = 1'b1
    } reset_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_KILL
    } fetch_state_t;

    typedef enum logic {
        D_IDLE,
        D_WAIT
    } dmem_state_t;

    typedef struct packed {
        logic F;
        logic D;
        logic E;
        logic M;
    } stall_vec_t;

    function automatic logic any_stall(input stall_vec_t s);
        return |s;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fetch.sv
// Instruction-fetch handshake FSM: keeps one request on the bus and drops the
// response that belongs to a path squashed by a redirect.
module fetch_handshake_fsm
    import pipes::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         iresp_data_ok,
    input  logic         redirect,
    input  logic         stall_F,
    output logic         ireq_valid,
    output logic         Iwait,
    output logic         discard_iresp,
    output fetch_state_t state
);

    fetch_state_t state_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= F_IDLE;
        else        state <= state_nxt;
    end

    // Outputs never look at stall_F, which itself depends on Iwait.
    always_comb begin
        ireq_valid    = 1'b0;
        Iwait         = 1'b0;
        discard_iresp = 1'b0;
        case (state)
            F_REQ: begin
                ireq_valid    = 1'b1;
                Iwait         = !iresp_data_ok;
                discard_iresp = iresp_data_ok && redirect;
            end
            F_KILL: begin
                ireq_valid    = 1'b1;
                Iwait         = 1'b1;
                discard_iresp = iresp_data_ok;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            F_IDLE: if (!stall_F) state_nxt = F_REQ;
            F_REQ: begin
                if (iresp_data_ok) begin
                    if (!redirect && stall_F) state_nxt = F_IDLE;
                end else if (redirect) begin
                    state_nxt = F_KILL;
                end
            end
            F_KILL: if (iresp_data_ok) state_nxt = F_REQ;
            default: state_nxt = F_IDLE;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: merges memory waits, multicycle EXE, load-use and
// redirects into per-stage stalls and IF/ID, ID/EX flush codes.
module pipe_hazard_ctrl
    import pipes::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   iresp_data_ok,
    input  logic                   dreq_valid,
    input  logic                   dresp_data_ok,
    input  logic                   exe_busy,
    input  logic                   load_use,
    input  logic                   redirect,
    output logic                   ireq_valid,
    output logic                   Iwait,
    output logic                   Dwait,
    output logic                   discard_iresp,
    output logic                   stall_F,
    output logic                   stall_D,
    output logic                   stall_E,
    output logic                   stall_M,
    output reset_t                 reset_IF_ID,
    output reset_t                 reset_ID_EX,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    dmem_state_t  d_state, d_state_nxt;
    fetch_state_t f_state;
    stall_vec_t   stall;
    logic         dwait_raw;

    fetch_handshake_fsm u_fetch (
        .clk           (clk),
        .reset         (reset),
        .iresp_data_ok (iresp_data_ok),
        .redirect      (redirect),
        .stall_F       (stall_F),
        .ireq_valid    (ireq_valid),
        .Iwait         (Iwait),
        .discard_iresp (discard_iresp),
        .state         (f_state)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) d_state <= D_IDLE;
        else        d_state <= d_state_nxt;
    end

    always_comb begin
        d_state_nxt = d_state;
        dwait_raw   = 1'b0;
        case (d_state)
            D_IDLE: begin
                if (dreq_valid && !dresp_data_ok) begin
                    dwait_raw   = 1'b1;
                    d_state_nxt = D_WAIT;
                end
            end
            D_WAIT: begin
                dwait_raw = !dresp_data_ok;
                if (dresp_data_ok) d_state_nxt = D_IDLE;
            end
            default: d_state_nxt = D_IDLE;
        endcase
    end

    // A request raised while reset is low must not show up as a wait.
    assign Dwait = reset && dwait_raw;

    // Redirect squashes the younger instructions, so it outranks load-use and Iwait.
    always_comb begin
        stall       = '0;
        reset_IF_ID = RESET_CONTINUE;
        reset_ID_EX = RESET_CONTINUE;
        if (!reset) begin
            reset_IF_ID = RESET_RESET;
            reset_ID_EX = RESET_RESET;
        end else if (Dwait) begin
            stall = stall_vec_t'(4'b1111);
        end else if (exe_busy) begin
            stall.F = 1'b1;
            stall.D = 1'b1;
            stall.E = 1'b1;
        end else if (redirect) begin
            reset_IF_ID = RESET_RESET;
            reset_ID_EX = RESET_RESET;
        end else if (load_use) begin
            stall.F     = 1'b1;
            stall.D     = 1'b1;
            reset_ID_EX = RESET_RESET;
        end else if (Iwait) begin
            stall.F     = 1'b1;
            reset_IF_ID = RESET_RESET;
        end
    end

    assign stall_F = stall.F;
    assign stall_D = stall.D;
    assign stall_E = stall.E;
    assign stall_M = stall.M;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (any_stall(stall) && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed checks of pipe_hazard_ctrl against a cycle-level
// behavioural model of the fetch/data handshakes and stall priority rules.
module tb_pipe_hazard_ctrl;
    import pipes::*;

    localparam int CW     = 6;
    localparam int CW_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          iresp_data_ok = 1'b0, dreq_valid = 1'b0, dresp_data_ok = 1'b0;
    logic          exe_busy = 1'b0, load_use = 1'b0, redirect = 1'b0;
    logic          ireq_valid, Iwait, Dwait, discard_iresp;
    logic          stall_F, stall_D, stall_E, stall_M;
    reset_t        reset_IF_ID, reset_ID_EX;
    logic [CW-1:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_hazard_ctrl #(.STALL_CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .iresp_data_ok (iresp_data_ok),
        .dreq_valid    (dreq_valid),
        .dresp_data_ok (dresp_data_ok),
        .exe_busy      (exe_busy),
        .load_use      (load_use),
        .redirect      (redirect),
        .ireq_valid    (ireq_valid),
        .Iwait         (Iwait),
        .Dwait         (Dwait),
        .discard_iresp (discard_iresp),
        .stall_F       (stall_F),
        .stall_D       (stall_D),
        .stall_E       (stall_E),
        .stall_M       (stall_M),
        .reset_IF_ID   (reset_IF_ID),
        .reset_ID_EX   (reset_ID_EX),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    // Model: is a fetch open on the bus, is its response stale, is a data access pending.
    bit            m_open, m_squash, m_dout;
    int            m_cnt;
    logic [9:0]    e_vec;
    logic [CW-1:0] e_cnt;
    bit            e_any, e_stallF;

    function automatic logic [9:0] obs_vec();
        return {ireq_valid, Iwait, Dwait, discard_iresp, stall_F, stall_D, stall_E, stall_M,
                reset_IF_ID == RESET_RESET, reset_ID_EX == RESET_RESET};
    endfunction

    function automatic bit model_dwait(input bit dreq, input bit dok);
        return m_dout ? !dok : (dreq && !dok);
    endfunction

    function automatic void model_out();
        bit iw, dw, dis, sf, sd, se, sm, rif, rie;
        iw  = m_open && (m_squash || !iresp_data_ok);
        dis = m_open && iresp_data_ok && (m_squash || redirect);
        dw  = model_dwait(dreq_valid, dresp_data_ok);
        {sf, sd, se, sm, rif, rie} = 6'b0;
        if (dw)            {sf, sd, se, sm} = 4'b1111;
        else if (exe_busy) {sf, sd, se} = 3'b111;
        else if (redirect) {rif, rie} = 2'b11;
        else if (load_use) {sf, sd, rie} = 3'b111;
        else if (iw)       {sf, rif} = 2'b11;
        e_vec    = {m_open, iw, dw, dis, sf, sd, se, sm, rif, rie};
        e_any    = sf | sd | se | sm;
        e_stallF = sf;
        e_cnt    = CW'(m_cnt);
    endfunction

    function automatic void model_next();
        if (!m_open)                m_open = !e_stallF;
        else if (m_squash)          begin if (iresp_data_ok) m_squash = 1'b0; end
        else if (iresp_data_ok)     begin if (!redirect) m_open = !e_stallF; end
        else if (redirect)          m_squash = 1'b1;
        m_dout = model_dwait(dreq_valid, dresp_data_ok);
        if (e_any && m_cnt < CW_MAX) m_cnt++;
    endfunction

    task automatic drive(input bit iok, input bit dreq, input bit dok,
                         input bit busy, input bit lu, input bit rd);
        iresp_data_ok = iok; dreq_valid = dreq; dresp_data_ok = dok;
        exe_busy = busy; load_use = lu; redirect = rd;
        @(negedge clk);
        model_out();
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        {iresp_data_ok, dreq_valid, dresp_data_ok, exe_busy, load_use, redirect} = 6'b0;
        m_open = 0; m_squash = 0; m_dout = 0; m_cnt = 0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset) assert (!(redirect && (Dwait || exe_busy)))
            else $error("illegal redirect during Dwait/exe_busy");
    end

    task automatic test_reset();
        #2 reset = 1'b0;
        {iresp_data_ok, dreq_valid, exe_busy, load_use, redirect} = 5'b11111;
        dresp_data_ok = 1'b0;
        #1;
        n_cmp++;
        if (obs_vec() !== 10'b0000000011) begin
            n_bad++; $display("FAIL reset_outputs: got %b want %b", obs_vec(), 10'b0000000011);
        end
        @(negedge clk);
        n_cmp++;
        if (stall_cycles !== '0) begin
            n_bad++; $display("FAIL reset_counter: got %0d want 0", stall_cycles);
        end
        do_reset();
    endtask

    task automatic test_fetch_stream();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            n_cmp++;
            if (obs_vec() !== e_vec) begin
                n_bad++; $display("FAIL fetch_stream[%0d]: got %b want %b", i, obs_vec(), e_vec);
            end
            if (i == 1) begin
                n_cmp++;
                if (ireq_valid !== 1'b1) begin
                    n_bad++; $display("FAIL first_ireq: got %b want 1", ireq_valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_iwait();
        for (int i = 0; i < 4; i++) begin
            drive(i == 3, 0, 0, 0, 0, 0);
            n_cmp++;
            if (obs_vec() !== e_vec) begin
                n_bad++; $display("FAIL iwait[%0d]: got %b want %b", i, obs_vec(), e_vec);
            end
            n_cmp++;
            if ({Iwait, stall_F, reset_IF_ID == RESET_RESET} !== {3{i != 3}}) begin
                n_bad++; $display("FAIL iwait_flush[%0d]: got %b%b%b want %b", i, Iwait, stall_F,
                                  reset_IF_ID == RESET_RESET, {3{i != 3}});
            end
            tick();
        end
    endtask

    task automatic test_redirect_kill();
        bit ok_seq [5] = '{0, 0, 1, 1, 1};
        bit rd_seq [5] = '{1, 0, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            drive(ok_seq[i], 0, 0, 0, 0, rd_seq[i]);
            n_cmp++;
            if (obs_vec() !== e_vec) begin
                n_bad++; $display("FAIL redirect_kill[%0d]: got %b want %b", i, obs_vec(), e_vec);
            end
            if (i == 2) begin
                n_cmp++;
                if (discard_iresp !== 1'b1) begin
                    n_bad++; $display("FAIL kill_discard: got %b want 1", discard_iresp);
                end
            end
            tick();
        end
    endtask

    task automatic test_dwait_exe();
        do_reset();
        for (int i = 0; i < 2; i++) begin drive(1, 0, 0, 0, 0, 0); tick(); end
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, i == 5, i != 5, 0, 0);
            n_cmp++;
            if (obs_vec() !== e_vec) begin
                n_bad++; $display("FAIL dwait_exe[%0d]: got %b want %b", i, obs_vec(), e_vec);
            end
            n_cmp++;
            if ({stall_F, stall_D, stall_E, stall_M} !== ((i < 5) ? 4'b1111 : 4'b0000)) begin
                n_bad++; $display("FAIL dwait_stalls[%0d]: got %b%b%b%b", i, stall_F, stall_D, stall_E, stall_M);
            end
            tick();
        end
        n_cmp++;
        if (stall_cycles !== CW'(5)) begin
            n_bad++; $display("FAIL dwait_count: got %0d want 5", stall_cycles);
        end
    endtask

    task automatic test_redirect_load_use();
        drive(1, 0, 0, 0, 1, 1);
        n_cmp++;
        if (obs_vec() !== e_vec) begin
            n_bad++; $display("FAIL redir_lu: got %b want %b", obs_vec(), e_vec);
        end
        n_cmp++;
        if ({stall_F, reset_IF_ID == RESET_RESET, reset_ID_EX == RESET_RESET} !== 3'b011) begin
            n_bad++; $display("FAIL redir_lu_flush: got %b%b%b want 011", stall_F,
                              reset_IF_ID == RESET_RESET, reset_ID_EX == RESET_RESET);
        end
        tick();
        drive(1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs_vec() !== e_vec) begin
            n_bad++; $display("FAIL redir_lu_after: got %b want %b", obs_vec(), e_vec);
        end
        tick();
    endtask

    task automatic test_async_reset();
        drive(1, 1, 0, 0, 0, 0);
        tick();
        dreq_valid = 1'b1; dresp_data_ok = 1'b0;
        #1;
        n_cmp++;
        if ({Dwait, stall_M} !== 2'b11) begin
            n_bad++; $display("FAIL dwait_before_reset: got %b%b want 11", Dwait, stall_M);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs_vec() !== 10'b0000000011) begin
            n_bad++; $display("FAIL async_reset: got %b want %b", obs_vec(), 10'b0000000011);
        end
        n_cmp++;
        if (stall_cycles !== '0) begin
            n_bad++; $display("FAIL async_reset_cnt: got %0d want 0", stall_cycles);
        end
        do_reset();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < CW_MAX + 8; i++) begin
            drive(1, 0, 0, 1, 0, 0);
            n_cmp++;
            if (stall_cycles !== e_cnt) begin
                n_bad++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, stall_cycles, e_cnt);
            end
            tick();
        end
        n_cmp++;
        if (stall_cycles !== CW'(CW_MAX)) begin
            n_bad++; $display("FAIL saturated: got %0d want %0d", stall_cycles, CW_MAX);
        end
    endtask

    task automatic test_random();
        bit iok, dreq, dok, busy, lu, rd;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            iok  = ($urandom_range(0, 2) != 0);
            dreq = ($urandom_range(0, 4) == 0);
            dok  = ($urandom_range(0, 2) == 0);
            busy = ($urandom_range(0, 5) == 0);
            lu   = ($urandom_range(0, 4) == 0);
            rd   = ($urandom_range(0, 5) == 0) && !busy && !model_dwait(dreq, dok);
            drive(iok, dreq, dok, busy, lu, rd);
            n_cmp++;
            if (obs_vec() !== e_vec) begin
                n_bad++; $display("FAIL random[%0d]: got %b want %b", i, obs_vec(), e_vec);
            end
            n_cmp++;
            if (stall_cycles !== e_cnt) begin
                n_bad++; $display("FAIL random_cnt[%0d]: got %0d want %0d", i, stall_cycles, e_cnt);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fetch_stream();
        test_iwait();
        test_redirect_kill();
        test_dwait_exe();
        test_redirect_load_use();
        test_async_reset();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
